// File: rtl/instruction_loader.sv
// instruction_loader
//   Receives a byte stream (16-bit little-endian word count N, then N
//   little-endian 32-bit words) and writes each assembled word into
//   instruction memory at BASE_ADDR + 4*index while holding the CPU.
//
//   state  | meaning
//   IDLE   | waiting for the first start request after reset
//   CNT_LO | taking the low byte of the word count
//   CNT_HI | taking the high byte of the word count, range check
//   DATA   | assembling the four bytes of the current word
//   WRITE  | one-cycle memory write strobe for the assembled word
//   DONE   | session completed, CPU released, waiting for start
//   ERR    | word count illegal, CPU held, waiting for start
//
// Ports
//   CLK, RST          clock, asynchronous active-low reset
//   start             one-cycle load request (IDLE/DONE/ERR only)
//   byte_valid/_data  incoming byte stream
//   byte_ready        byte accepted on this cycle's edge when valid
//   RW, Addr, DataIn  instruction memory write strobe, byte address, word
//   cpu_hold          CPU held everywhere except DONE
//   load_done         session finished successfully
//   load_err          session aborted on illegal word count
module instruction_loader #(
  parameter logic [31:0] BASE_ADDR = 32'd0,
  parameter int          MAX_WORDS = 256
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        RW,
  output logic [31:0] Addr,
  output logic [31:0] DataIn,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_err
);

  localparam int IW = $clog2(MAX_WORDS + 1);

  typedef enum logic [2:0] {
    IDLE, CNT_LO, CNT_HI, DATA, WRITE, DONE, ERR
  } state_t;

  state_t        state, state_nxt;
  logic [15:0]   count;
  logic [IW-1:0] word_idx;
  logic [1:0]    byte_idx;
  logic [23:0]   asm_lo;
  logic [15:0]   n_new;
  logic          last_word;

  // Count as it will be once the high byte currently on the bus is taken.
  assign n_new     = {byte_data, count[7:0]};
  assign last_word = (32'(word_idx) + 32'd1) == 32'(count);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    byte_ready = 1'b0;
    RW         = 1'b0;
    cpu_hold   = 1'b1;
    load_done  = 1'b0;
    load_err   = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = CNT_LO;
      end
      CNT_LO: begin
        byte_ready = 1'b1;
        if (byte_valid) state_nxt = CNT_HI;
      end
      CNT_HI: begin
        byte_ready = 1'b1;
        if (byte_valid) begin
          if (n_new == 16'd0)                     state_nxt = DONE;
          else if (32'(n_new) > 32'(MAX_WORDS))   state_nxt = ERR;
          else                                    state_nxt = DATA;
        end
      end
      DATA: begin
        byte_ready = 1'b1;
        if (byte_valid && byte_idx == 2'd3) state_nxt = WRITE;
      end
      WRITE: begin
        RW        = 1'b1;
        state_nxt = last_word ? DONE : DATA;
      end
      DONE: begin
        cpu_hold  = 1'b0;
        load_done = 1'b1;
        if (start) state_nxt = CNT_LO;
      end
      ERR: begin
        load_err = 1'b1;
        if (start) state_nxt = CNT_LO;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Addr/DataIn are loaded together with the last byte of a word so they are
  // already stable for the whole WRITE cycle, then held until the next word.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      count    <= '0;
      word_idx <= '0;
      byte_idx <= '0;
      asm_lo   <= '0;
      Addr     <= '0;
      DataIn   <= '0;
    end else begin
      case (state)
        CNT_LO: begin
          if (byte_valid) count[7:0] <= byte_data;
        end
        CNT_HI: begin
          if (byte_valid) begin
            count[15:8] <= byte_data;
            word_idx    <= '0;
            byte_idx    <= '0;
          end
        end
        DATA: begin
          if (byte_valid) begin
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
              2'd0: asm_lo[7:0]   <= byte_data;
              2'd1: asm_lo[15:8]  <= byte_data;
              2'd2: asm_lo[23:16] <= byte_data;
              default: begin
                DataIn <= {byte_data, asm_lo};
                Addr   <= BASE_ADDR + (32'(word_idx) << 2);
              end
            endcase
          end
        end
        WRITE: begin
          word_idx <= word_idx + IW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_loader.sv
// tb_instruction_loader
//   Random and directed load sessions on two loaders (BASE_ADDR 0 and 128)
//   sharing one input stream. A byte-count level model predicts every
//   output each cycle; directed sessions pin literal write values.
module tb_instruction_loader;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;

  logic        ready_a, rw_a, hold_a, done_a, err_a;
  logic [31:0] addr_a, data_a;
  logic        ready_b, rw_b, hold_b, done_b, err_b;
  logic [31:0] addr_b, data_b;

  instruction_loader #(.BASE_ADDR(32'd0), .MAX_WORDS(256)) u_dut_a (
    .CLK(CLK), .RST(RST), .start(start), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(ready_a), .RW(rw_a), .Addr(addr_a),
    .DataIn(data_a), .cpu_hold(hold_a), .load_done(done_a), .load_err(err_a)
  );

  instruction_loader #(.BASE_ADDR(32'd128), .MAX_WORDS(256)) u_dut_b (
    .CLK(CLK), .RST(RST), .start(start), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(ready_b), .RW(rw_b), .Addr(addr_b),
    .DataIn(data_b), .cpu_hold(hold_b), .load_done(done_b), .load_err(err_b)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: session progress measured in bytes consumed and words written.
  typedef enum {M_IDLE, M_LOAD, M_DONE, M_ERR} mode_t;
  mode_t       m_mode;
  int          m_b, m_n, m_w, m_k;
  bit          m_pend;
  logic [31:0] m_word, m_addr_a, m_addr_b, m_data;

  logic [31:0] wa_addr[$];
  logic [31:0] wa_data[$];
  logic [31:0] wb_addr[$];

  task automatic model_reset();
    m_mode = M_IDLE; m_b = 0; m_n = 0; m_w = 0; m_pend = 0;
    m_word = '0; m_addr_a = '0; m_addr_b = '0; m_data = '0;
  endtask

  initial model_reset();

  always @(posedge CLK) begin
    if (!RST) begin
      model_reset();
    end else if (m_mode == M_LOAD) begin
      if (m_pend) begin
        m_pend = 0;
        m_w++;
        if (m_w == m_n) m_mode = M_DONE;
      end else if (byte_valid) begin
        if (m_b == 0) begin
          m_n = int'(byte_data);
        end else if (m_b == 1) begin
          m_n = m_n + 256 * int'(byte_data);
          if (m_n == 0)        m_mode = M_DONE;
          else if (m_n > 256)  m_mode = M_ERR;
        end else begin
          m_k = (m_b - 2) % 4;
          m_word[8*m_k +: 8] = byte_data;
          if (m_k == 3) begin
            m_pend   = 1;
            m_addr_a = 32'(4 * m_w);
            m_addr_b = 32'(128 + 4 * m_w);
            m_data   = m_word;
          end
        end
        m_b++;
      end
    end else if (start) begin
      m_mode = M_LOAD; m_b = 0; m_w = 0;
    end
    #1;
    check("rw_a",      rw_a,    m_pend);
    check("ready_a",   ready_a, (m_mode == M_LOAD) && !m_pend);
    check("hold_a",    hold_a,  m_mode != M_DONE);
    check("done_a",    done_a,  m_mode == M_DONE);
    check("err_a",     err_a,   m_mode == M_ERR);
    check("addr_a",    addr_a,  m_addr_a);
    check("data_a",    data_a,  m_data);
    check("rw_b",      rw_b,    m_pend);
    check("ready_b",   ready_b, (m_mode == M_LOAD) && !m_pend);
    check("addr_b",    addr_b,  m_addr_b);
    check("data_b",    data_b,  m_data);
    if (rw_a === 1'b1) begin
      wa_addr.push_back(addr_a);
      wa_data.push_back(data_a);
    end
    if (rw_b === 1'b1) wb_addr.push_back(addr_b);
  end

  logic [7:0] stream[$];

  task automatic clear_log();
    wa_addr.delete(); wa_data.delete(); wb_addr.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input bit noisy);
    int tries;
    repeat (gap) begin
      byte_valid = 1'b0;
      byte_data  = 8'($urandom);
      start      = noisy && ($urandom_range(0, 2) == 0);
      @(negedge CLK);
      start = 1'b0;
    end
    byte_valid = 1'b1;
    byte_data  = b;
    tries = 0;
    while (!ready_a && tries < 100) begin
      @(negedge CLK);
      tries++;
    end
    if (tries >= 100) begin
      total++; bad++;
      $display("FAIL byte_timeout: got no byte_ready expected byte_ready within 100 cycles");
    end
    @(negedge CLK);
    byte_valid = 1'b0;
  endtask

  task automatic reset_pulse();
    #2 RST = 1'b0;
    #1;
    check("rst_rw",    rw_a,    1'b0);
    check("rst_addr",  addr_a,  32'h0);
    check("rst_data",  data_a,  32'h0);
    check("rst_ready", ready_a, 1'b0);
    check("rst_hold",  hold_a,  1'b1);
    check("rst_done",  done_a,  1'b0);
    check("rst_err",   err_a,   1'b0);
    check("rst_addrb", addr_b,  32'h0);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
  endtask

  // Runs one session from the current negedge; abort_at >= 0 resets the
  // loaders just before that byte index would be sent.
  task automatic run_stream(input int min_gap, input int max_gap, input bit noisy, input int abort_at);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    for (int i = 0; i < stream.size(); i++) begin
      if (i == abort_at) begin
        reset_pulse();
        return;
      end
      send_byte(stream[i], $urandom_range(min_gap, max_gap), noisy);
    end
    repeat (3) @(negedge CLK);
  endtask

  task automatic build_random(input int n);
    stream.delete();
    stream.push_back(8'(n));
    stream.push_back(8'(n >> 8));
    if (n <= 256)
      for (int i = 0; i < 4 * n; i++) stream.push_back(8'($urandom));
  endtask

  initial begin
    #1 RST = 1'b0;
    @(negedge CLK);
    check("init_rw",   rw_a,   1'b0);
    check("init_hold", hold_a, 1'b1);
    check("init_addr", addr_a, 32'h0);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);

    // Two words from address 0.
    clear_log();
    stream = '{8'h02, 8'h00, 8'h02, 8'h00, 8'h00, 8'hE0, 8'h01, 8'h00, 8'h01, 8'h08};
    run_stream(0, 0, 0, -1);
    check("two_words_count", wa_addr.size(), 2);
    if (wa_addr.size() == 2) begin
      check("w0_addr", wa_addr[0], 32'h0);
      check("w0_data", wa_data[0], 32'hE000_0002);
      check("w1_addr", wa_addr[1], 32'h4);
      check("w1_data", wa_data[1], 32'h0801_0001);
    end
    check("two_words_done", done_a, 1'b1);
    check("two_words_hold", hold_a, 1'b0);

    // Zero words.
    clear_log();
    stream = '{8'h00, 8'h00};
    run_stream(0, 0, 0, -1);
    check("zero_writes", wa_addr.size(), 0);
    check("zero_done",   done_a, 1'b1);

    // N = 257 is one over the limit.
    clear_log();
    stream = '{8'h01, 8'h01};
    run_stream(0, 0, 0, -1);
    check("err_flag",   err_a,  1'b1);
    check("err_hold",   hold_a, 1'b1);
    check("err_writes", wa_addr.size(), 0);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    check("err_cleared", err_a,   1'b0);
    check("err_restart", ready_a, 1'b1);

    // One word with three idle cycles before every byte (start ignored).
    clear_log();
    stream = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    run_stream(3, 3, 0, -1);
    check("gap_writes", wa_addr.size(), 1);
    if (wa_data.size() == 1) check("gap_data", wa_data[0], 32'h4433_2211);

    // Reset after two data bytes, then a normal session.
    clear_log();
    stream = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    run_stream(0, 0, 0, 4);
    check("abort_writes", wa_addr.size(), 0);
    clear_log();
    stream = '{8'h01, 8'h00, 8'h5A, 8'h6B, 8'h7C, 8'h8D};
    run_stream(0, 1, 0, -1);
    check("after_abort_writes", wa_addr.size(), 1);
    if (wa_data.size() == 1) check("after_abort_data", wa_data[0], 32'h8D7C_6B5A);

    // Three words on the BASE_ADDR=128 loader with start noise during DATA.
    clear_log();
    build_random(3);
    run_stream(1, 3, 1, -1);
    check("base_writes", wb_addr.size(), 3);
    if (wb_addr.size() == 3) begin
      check("base_addr0", wb_addr[0], 32'd128);
      check("base_addr1", wb_addr[1], 32'd132);
      check("base_addr2", wb_addr[2], 32'd136);
    end

    // Largest legal session, back to back.
    clear_log();
    build_random(256);
    run_stream(0, 0, 0, -1);
    check("max_writes", wa_addr.size(), 256);
    check("max_done",   done_a, 1'b1);
    if (wa_addr.size() == 256) check("max_last_addr", wa_addr[255], 32'd1020);

    // Random sessions.
    for (int s = 0; s < 40; s++) begin
      int sel, n, abort;
      sel = $urandom_range(0, 9);
      if (sel == 0)      n = 0;
      else if (sel == 1) n = $urandom_range(257, 2000);
      else               n = $urandom_range(1, 6);
      build_random(n);
      abort = ($urandom_range(0, 9) == 0) ? $urandom_range(0, stream.size() - 1) : -1;
      run_stream(0, 3, $urandom_range(0, 1), abort);
      repeat ($urandom_range(1, 4)) begin
        byte_valid = 1'($urandom);
        byte_data  = 8'($urandom);
        @(negedge CLK);
      end
      byte_valid = 1'b0;
    end

    repeat (3) @(negedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
